// File: rtl/sdram_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_line_reader
//  Description : Fetches a frame from SDRAM as a sequence of full-page read
//                bursts and buffers the returned words in a first-word-fall-
//                through pixel FIFO for a streaming consumer.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_line_reader #(
    parameter int PAGE_WORDS = 512,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [14:0] start_addr,
    input  logic [14:0] num_pages,
    input  logic        ctl_ready,
    output logic        ctl_rw_en,
    output logic        ctl_rw,
    output logic [14:0] ctl_addr,
    input  logic [15:0] ctl_data,
    input  logic        ctl_data_valid,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        underflow,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(PAGE_WORDS) + 1;

    localparam logic [AW:0]   c_depth      = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   c_page_space = (AW+1)'(PAGE_WORDS);
    localparam logic [AW:0]   c_cnt_one    = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);
    localparam logic [WW-1:0] c_last_word  = WW'(PAGE_WORDS - 1);
    localparam logic [WW-1:0] c_word_one   = WW'(1);
    localparam logic [14:0]   c_page_one   = 15'd1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SPACE = 3'd1,
        ST_REQ        = 3'd2,
        ST_BURST      = 3'd3,
        ST_NEXT       = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_ctl_rw_en;
    logic [14:0]     r_ctl_addr;
    logic [14:0]     r_start_addr;
    logic [14:0]     r_num_pages;
    logic [14:0]     r_page_cnt;
    logic [WW-1:0]   r_word_cnt;
    logic            r_flush_pending;
    logic            r_underflow;
    logic            r_overflow;

    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_bursting;
    logic            w_last;
    logic            w_discard;
    logic            w_push_try;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_pix_valid;
    logic            w_space_ok;
    logic [AW:0]     w_free;
    logic [14:0]     w_new_pages;
    logic [14:0]     w_page_next;

    assign w_pix_valid = (r_count != '0);
    assign w_full      = (r_count == c_depth);
    assign w_free      = c_depth - r_count;
    assign w_space_ok  = (w_free >= c_page_space);
    assign w_bursting  = (r_state == ST_BURST);
    assign w_last      = w_bursting && ctl_data_valid && (r_word_cnt == c_last_word);
    // Words of a burst interrupted by frame_start belong to the old frame.
    assign w_discard   = r_flush_pending || frame_start;
    assign w_push_try  = w_bursting && ctl_data_valid && !w_discard;
    // The pending flush of an interrupted burst is applied on its last word.
    assign w_flush     = frame_start || (w_last && r_flush_pending);
    assign w_push      = w_push_try && !w_full && !w_flush;
    assign w_pop       = w_pix_valid && pix_ready && !w_flush;
    assign w_new_pages = frame_start ? num_pages : r_num_pages;
    assign w_page_next = r_page_cnt + c_page_one;

    assign ctl_rw_en = r_ctl_rw_en;
    assign ctl_rw    = 1'b1;
    assign ctl_addr  = r_ctl_addr;
    assign pix_valid = w_pix_valid;
    assign pix_data  = w_pix_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign busy      = (r_state != ST_IDLE);
    assign underflow = r_underflow;
    assign overflow  = r_overflow;

    // Page fetch sequencer: request a page, count its burst, advance or restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_ctl_rw_en     <= 1'b0;
            r_ctl_addr      <= '0;
            r_start_addr    <= '0;
            r_num_pages     <= '0;
            r_page_cnt      <= '0;
            r_word_cnt      <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_start_addr <= start_addr;
                        r_num_pages  <= num_pages;
                        r_page_cnt   <= '0;
                        if (num_pages != '0)
                            r_state <= ST_WAIT_SPACE;
                    end
                end
                ST_WAIT_SPACE: begin
                    if (frame_start) begin
                        r_start_addr <= start_addr;
                        r_num_pages  <= num_pages;
                        r_page_cnt   <= '0;
                        r_state      <= (num_pages == '0) ? ST_IDLE : ST_WAIT_SPACE;
                    end else if (w_space_ok) begin
                        r_ctl_rw_en <= 1'b1;
                        r_ctl_addr  <= r_start_addr + r_page_cnt;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (frame_start) begin
                        r_ctl_rw_en  <= 1'b0;
                        r_start_addr <= start_addr;
                        r_num_pages  <= num_pages;
                        r_page_cnt   <= '0;
                        r_state      <= (num_pages == '0) ? ST_IDLE : ST_WAIT_SPACE;
                    end else if (ctl_ready) begin
                        r_ctl_rw_en <= 1'b0;
                        r_word_cnt  <= '0;
                        r_state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // The controller cannot be stopped, so the burst always runs to its end.
                    if (frame_start) begin
                        r_start_addr <= start_addr;
                        r_num_pages  <= num_pages;
                    end
                    if (w_last) begin
                        r_flush_pending <= 1'b0;
                        if (w_discard) begin
                            r_page_cnt <= '0;
                            r_state    <= (w_new_pages == '0) ? ST_IDLE : ST_WAIT_SPACE;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end else begin
                        if (ctl_data_valid)
                            r_word_cnt <= r_word_cnt + c_word_one;
                        if (frame_start)
                            r_flush_pending <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (frame_start) begin
                        r_start_addr <= start_addr;
                        r_num_pages  <= num_pages;
                        r_page_cnt   <= '0;
                        r_state      <= (num_pages == '0) ? ST_IDLE : ST_WAIT_SPACE;
                    end else begin
                        r_page_cnt <= w_page_next;
                        r_state    <= (w_page_next == r_num_pages) ? ST_IDLE : ST_WAIT_SPACE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ctl_rw_en <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= ctl_data;
    end

    // FIFO pointers and occupancy; a flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags, cleared when a new frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (frame_start) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (pix_ready && !w_pix_valid && (r_state != ST_IDLE))
                r_underflow <= 1'b1;
            if (w_push_try && w_full)
                r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire
